// File: rtl/ram_dp_clear_pkg.sv
// Shared definitions for the dual-port RAM with clear engine:
// read-during-write mode codes, FSM state encoding and address range helper.
package ram_dp_clear_pkg;

  localparam int RW_READ_FIRST  = 0;
  localparam int RW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Non-power-of-two depths leave a hole at the top of the address space.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_dp_clear_if.sv
// Port bundle for ram_dp_clear: CPU read/write port A, scanner read port B,
// plus clear-engine status and FSM debug state.
interface ram_dp_clear_if
  import ram_dp_clear_pkg::*;
#(
  parameter int DEPTH = 2**14,
  parameter int WIDTH = 16
);

  localparam int AW = $clog2(DEPTH);

  // Requests are sampled at the rising edge and are only accepted while
  // o_Ready=1. There is no backpressure: an accepted read sets o_*_Valid for
  // exactly the following cycle with o_*_Data updated; otherwise Valid=0 and
  // Data holds its last value.
  logic             i_A_EN;
  logic             i_A_Write_EN;
  logic [AW-1:0]    i_A_Address;
  logic [WIDTH-1:0] i_A_Data;
  logic [WIDTH-1:0] o_A_Data;
  logic             o_A_Valid;

  logic             i_B_EN;
  logic [AW-1:0]    i_B_Address;
  logic [WIDTH-1:0] o_B_Data;
  logic             o_B_Valid;

  logic             o_Ready;
  logic [AW-1:0]    o_Clear_Addr;
  state_t           o_State;

  modport master (
    output i_A_EN, i_A_Write_EN, i_A_Address, i_A_Data, i_B_EN, i_B_Address,
    input  o_A_Data, o_A_Valid, o_B_Data, o_B_Valid, o_Ready, o_Clear_Addr, o_State
  );

  modport slave (
    input  i_A_EN, i_A_Write_EN, i_A_Address, i_A_Data, i_B_EN, i_B_Address,
    output o_A_Data, o_A_Valid, o_B_Data, o_B_Valid, o_Ready, o_Clear_Addr, o_State
  );

endinterface

// File: rtl/ram_clear_fsm.sv
// Clear engine: after reset sweeps one word per cycle from address 0 up to
// DEPTH-1, then parks in READY until the next reset.
module ram_clear_fsm
  import ram_dp_clear_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int AW             = $clog2(DEPTH)
) (
  input  logic          i_CLK,
  input  logic          i_RESET_n,
  output logic          o_clear_we,
  output logic [AW-1:0] o_clear_addr,
  output logic          o_ready,
  output state_t        o_state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    o_clear_we = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (!CLEAR_ON_RESET) begin
          // Skipping the sweep still reports the final address for consistency.
          state_nxt = ST_READY;
          cnt_nxt   = LAST_ADDR;
        end else begin
          o_clear_we = 1'b1;
          if (cnt == LAST_ADDR) begin
            state_nxt = ST_READY;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign o_clear_addr = cnt;
  assign o_ready      = (state == ST_READY);
  assign o_state      = state;

endmodule

// File: rtl/ram_dp_clear.sv
// Dual-port synchronous RAM (A: read/write CPU port, B: read-only scanner port)
// with a post-reset clear sweep and selectable read-during-write behaviour.
module ram_dp_clear
  import ram_dp_clear_pkg::*;
#(
  parameter int               DEPTH          = 2**14,
  parameter int               WIDTH          = 16,
  parameter int               RW_MODE        = RW_READ_FIRST,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
  input logic           i_CLK,
  input logic           i_RESET_n,
  ram_dp_clear_if.slave bus
);

  localparam int AW          = $clog2(DEPTH);
  localparam bit WRITE_FIRST = (RW_MODE == RW_WRITE_FIRST);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic          ready;
  state_t        state;

  ram_clear_fsm #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_fsm (
    .i_CLK        (i_CLK),
    .i_RESET_n    (i_RESET_n),
    .o_clear_we   (clear_we),
    .o_clear_addr (clear_addr),
    .o_ready      (ready),
    .o_state      (state)
  );

  logic             a_in_range;
  logic             b_in_range;
  logic             a_rd;
  logic             a_we;
  logic             b_rd;
  logic             collide;
  logic             mem_we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;

  always_comb begin
    a_in_range = addr_in_range(32'(bus.i_A_Address), DEPTH);
    b_in_range = addr_in_range(32'(bus.i_B_Address), DEPTH);
    a_rd       = ready & bus.i_A_EN;
    a_we       = a_rd & bus.i_A_Write_EN & a_in_range;
    b_rd       = ready & bus.i_B_EN;
    collide    = a_we & (bus.i_A_Address == bus.i_B_Address);

    // Sweep and port A never overlap: port A only writes once READY.
    mem_we = i_RESET_n & (clear_we | a_we);
    waddr  = clear_we ? clear_addr : bus.i_A_Address;
    wdata  = clear_we ? INIT_VALUE : bus.i_A_Data;

    a_word = '0;
    if (WRITE_FIRST && a_we) begin
      a_word = bus.i_A_Data;
    end else if (a_in_range) begin
      a_word = mem[bus.i_A_Address];
    end

    // Same-cycle A write to B's address: forward in WRITE_FIRST, else old word.
    b_word = '0;
    if (WRITE_FIRST && collide) begin
      b_word = bus.i_A_Data;
    end else if (b_in_range) begin
      b_word = mem[bus.i_B_Address];
    end
  end

  always_ff @(posedge i_CLK) begin
    if (mem_we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      bus.o_A_Data  <= '0;
      bus.o_A_Valid <= 1'b0;
      bus.o_B_Data  <= '0;
      bus.o_B_Valid <= 1'b0;
    end else begin
      bus.o_A_Valid <= a_rd;
      bus.o_B_Valid <= b_rd;
      if (a_rd) begin
        bus.o_A_Data <= a_word;
      end
      if (b_rd) begin
        bus.o_B_Data <= b_word;
      end
    end
  end

  assign bus.o_Ready      = ready;
  assign bus.o_Clear_Addr = clear_addr;
  assign bus.o_State      = state;

endmodule

// File: tb/tb_ram_dp_clear.sv
// Bench for ram_dp_clear: four configurations share one stimulus stream and are
// compared each cycle against an array-based model of the memory's rules.
module tb_ram_dp_clear;
  import ram_dp_clear_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: 16 words READ_FIRST, dut1: 16 words WRITE_FIRST,
  // dut2: 12 words WRITE_FIRST INIT=5A5A, dut3: 16 words, no sweep
  ram_dp_clear_if #(.DEPTH(16), .WIDTH(16)) if0 ();
  ram_dp_clear_if #(.DEPTH(16), .WIDTH(16)) if1 ();
  ram_dp_clear_if #(.DEPTH(12), .WIDTH(16)) if2 ();
  ram_dp_clear_if #(.DEPTH(16), .WIDTH(16)) if3 ();

  assign if1.i_A_EN = if0.i_A_EN;  assign if1.i_A_Write_EN = if0.i_A_Write_EN;
  assign if1.i_A_Address = if0.i_A_Address;  assign if1.i_A_Data = if0.i_A_Data;
  assign if1.i_B_EN = if0.i_B_EN;  assign if1.i_B_Address = if0.i_B_Address;
  assign if2.i_A_EN = if0.i_A_EN;  assign if2.i_A_Write_EN = if0.i_A_Write_EN;
  assign if2.i_A_Address = if0.i_A_Address;  assign if2.i_A_Data = if0.i_A_Data;
  assign if2.i_B_EN = if0.i_B_EN;  assign if2.i_B_Address = if0.i_B_Address;
  assign if3.i_A_EN = if0.i_A_EN;  assign if3.i_A_Write_EN = if0.i_A_Write_EN;
  assign if3.i_A_Address = if0.i_A_Address;  assign if3.i_A_Data = if0.i_A_Data;
  assign if3.i_B_EN = if0.i_B_EN;  assign if3.i_B_Address = if0.i_B_Address;

  ram_dp_clear #(.DEPTH(16), .WIDTH(16), .RW_MODE(0), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0000))
    dut0 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if0));
  ram_dp_clear #(.DEPTH(16), .WIDTH(16), .RW_MODE(1), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0000))
    dut1 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if1));
  ram_dp_clear #(.DEPTH(12), .WIDTH(16), .RW_MODE(1), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h5A5A))
    dut2 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if2));
  ram_dp_clear #(.DEPTH(16), .WIDTH(16), .RW_MODE(0), .CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0000))
    dut3 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if3));

  logic [15:0] obs_a_d[4];
  logic [15:0] obs_b_d[4];
  logic        obs_a_v[4];
  logic        obs_b_v[4];
  logic        obs_rdy[4];
  logic [3:0]  obs_ca[4];
  logic        obs_st[4];
  assign obs_a_d[0] = if0.o_A_Data;  assign obs_b_d[0] = if0.o_B_Data;
  assign obs_a_d[1] = if1.o_A_Data;  assign obs_b_d[1] = if1.o_B_Data;
  assign obs_a_d[2] = if2.o_A_Data;  assign obs_b_d[2] = if2.o_B_Data;
  assign obs_a_d[3] = if3.o_A_Data;  assign obs_b_d[3] = if3.o_B_Data;
  assign obs_a_v[0] = if0.o_A_Valid; assign obs_b_v[0] = if0.o_B_Valid;
  assign obs_a_v[1] = if1.o_A_Valid; assign obs_b_v[1] = if1.o_B_Valid;
  assign obs_a_v[2] = if2.o_A_Valid; assign obs_b_v[2] = if2.o_B_Valid;
  assign obs_a_v[3] = if3.o_A_Valid; assign obs_b_v[3] = if3.o_B_Valid;
  assign obs_rdy[0] = if0.o_Ready;   assign obs_ca[0] = if0.o_Clear_Addr;
  assign obs_rdy[1] = if1.o_Ready;   assign obs_ca[1] = if1.o_Clear_Addr;
  assign obs_rdy[2] = if2.o_Ready;   assign obs_ca[2] = if2.o_Clear_Addr;
  assign obs_rdy[3] = if3.o_Ready;   assign obs_ca[3] = if3.o_Clear_Addr;
  assign obs_st[0]  = if0.o_State;   assign obs_st[1] = if1.o_State;
  assign obs_st[2]  = if2.o_State;   assign obs_st[3] = if3.o_State;

  // ---------------- reference model ----------------
  int          dep[4] = '{16, 16, 12, 16};
  int          rwm[4] = '{0, 1, 1, 0};
  bit          clr[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] ini[4] = '{16'h0000, 16'h0000, 16'h5A5A, 16'h0000};
  logic [15:0] mm[4][16];
  int          n_edges[4];   // rising edges with reset high since last reset
  logic [15:0] ea_d[4];
  logic [15:0] eb_d[4];
  logic        ea_v[4];
  logic        eb_v[4];

  int checks = 0;
  int failures = 0;

  function automatic bit m_ready(int k);
    return n_edges[k] >= (clr[k] ? dep[k] : 1);
  endfunction

  function automatic logic [15:0] m_read(int k, int addr);
    return (addr < dep[k]) ? mm[k][addr] : 16'h0000;
  endfunction

  task automatic model_edge();
    int aa;
    int ba;
    bit wr;
    aa = int'(if0.i_A_Address);
    ba = int'(if0.i_B_Address);
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        n_edges[k] = 0;
        ea_d[k] = 16'h0;  eb_d[k] = 16'h0;
        ea_v[k] = 1'b0;   eb_v[k] = 1'b0;
      end else begin
        if (m_ready(k)) begin
          wr = if0.i_A_EN && if0.i_A_Write_EN && (aa < dep[k]);
          ea_v[k] = if0.i_A_EN;
          eb_v[k] = if0.i_B_EN;
          if (if0.i_A_EN) ea_d[k] = (rwm[k] == 1 && wr) ? if0.i_A_Data : m_read(k, aa);
          if (if0.i_B_EN) eb_d[k] = (rwm[k] == 1 && wr && ba == aa) ? if0.i_A_Data : m_read(k, ba);
          if (wr) mm[k][aa] = if0.i_A_Data;
        end else begin
          ea_v[k] = 1'b0;
          eb_v[k] = 1'b0;
        end
        if (n_edges[k] < 100000) n_edges[k]++;
        // Whole memory equals INIT_VALUE by the time the port opens.
        if (clr[k] && n_edges[k] == dep[k])
          for (int i = 0; i < 16; i++) mm[k][i] = ini[k];
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_ca;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_ready", k), 32'(obs_rdy[k]), 32'(m_ready(k)));
      chk($sformatf("d%0d_state", k), 32'(obs_st[k]), 32'(m_ready(k)));
      chk($sformatf("d%0d_a_valid", k), 32'(obs_a_v[k]), 32'(ea_v[k]));
      chk($sformatf("d%0d_b_valid", k), 32'(obs_b_v[k]), 32'(eb_v[k]));
      if (k < 3) begin
        chk($sformatf("d%0d_a_data", k), 32'(obs_a_d[k]), 32'(ea_d[k]));
        chk($sformatf("d%0d_b_data", k), 32'(obs_b_d[k]), 32'(eb_d[k]));
        exp_ca = 4'((n_edges[k] >= dep[k] - 1) ? dep[k] - 1 : n_edges[k]);
        chk($sformatf("d%0d_clear_addr", k), 32'(obs_ca[k]), 32'(exp_ca));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic a_en, input logic a_we, input logic [3:0] a_addr,
                       input logic [15:0] a_data, input logic b_en, input logic [3:0] b_addr);
    if0.i_A_EN = a_en;
    if0.i_A_Write_EN = a_we;
    if0.i_A_Address = a_addr;
    if0.i_A_Data = a_data;
    if0.i_B_EN = b_en;
    if0.i_B_Address = b_addr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int cnt);
    for (int i = 0; i < cnt; i++) cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  logic [3:0] ra;
  logic [3:0] rb;

  initial begin
    for (int k = 0; k < 4; k++) begin
      n_edges[k] = 0;
      ea_d[k] = 16'h0; eb_d[k] = 16'h0; ea_v[k] = 1'b0; eb_v[k] = 1'b0;
      for (int i = 0; i < 16; i++) mm[k][i] = 16'hxxxx;
    end
    idle();
    rst_n = 1'b0;
    cycles(2);

    // Release; a write and reads issued during the sweep must be ignored.
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4'd2, 16'h00FF, 1'b1, 4'd2);
    cycles(3);
    idle();
    cycles(14);

    // Full read-back of the swept memory on both ports.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 16'h0, 1'b1, 4'(15 - i));
      cycle();
    end

    // Write then read back on both ports.
    drive(1'b1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0);
    cycle();
    drive(1'b1, 1'b0, 4'd5, 16'h0, 1'b1, 4'd5);
    cycle();
    idle();
    cycle();

    // Collision: mem[3]=1111, then A writes 2222 to [3] while B reads [3].
    drive(1'b1, 1'b1, 4'd3, 16'h1111, 1'b0, 4'd0);
    cycle();
    drive(1'b1, 1'b1, 4'd3, 16'h2222, 1'b1, 4'd3);
    cycle();
    drive(1'b1, 1'b0, 4'd3, 16'h0, 1'b1, 4'd3);
    cycle();

    // Out-of-range on the 12-word instance: read 13, write 13, check 1 and 13.
    drive(1'b1, 1'b0, 4'd13, 16'h0, 1'b1, 4'd13);
    cycle();
    drive(1'b1, 1'b1, 4'd13, 16'h1234, 1'b1, 4'd13);
    cycle();
    drive(1'b1, 1'b0, 4'd1, 16'h0, 1'b1, 4'd13);
    cycle();
    idle();
    cycle();

    // Randomized traffic with frequent address collisions.
    for (int i = 0; i < 300; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom),
            1'($urandom_range(0, 1)), rb);
      cycle();
    end

    // Reset mid-sweep at address 7, held for two cycles, then a full sweep.
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycles(7);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(17);

    for (int i = 0; i < 60; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 16'($urandom),
            1'($urandom_range(0, 1)), rb);
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
